// File: rtl/axilite_rb_master_p.sv
// Command ring -> single-outstanding AXI4-Lite master engine -> response ring.
// Define AXILITE_RB_ERR_CNT_EN to add err_count, a saturating count of responses with status[1] set.
module axilite_rb_master_p #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 64,
    parameter int CMD_DEPTH  = 16,
    parameter int RESP_DEPTH = 16,
    localparam int STRB_W    = DATA_W / 8,
    localparam int CLW       = $clog2(CMD_DEPTH) + 1,
    localparam int RLW       = $clog2(RESP_DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,

    input  logic              cmd_push_req,
    output logic              cmd_push_ack,
    input  logic              cmd_push_struct_op,
    input  logic [ADDR_W-1:0] cmd_push_struct_address,
    input  logic [DATA_W-1:0] cmd_push_struct_wdata,
    input  logic [STRB_W-1:0] cmd_push_struct_wstrb,
    output logic              buffer_empty,
    output logic              buffer_full,
    output logic [CLW-1:0]    cmd_level,

    input  logic              resp_pop_req,
    output logic              resp_pop_ack,
    output logic              resp_pop_req_pulse,
    output logic              resp_pop_ready,
    output logic [RLW-1:0]    resp_level,
    output logic              resp_pop_struct_op,
    output logic [ADDR_W-1:0] resp_pop_struct_address,
    output logic [DATA_W-1:0] resp_pop_struct_rdata,
    output logic [1:0]        resp_pop_struct_status,
`ifdef AXILITE_RB_ERR_CNT_EN
    output logic [15:0]       err_count,
`endif

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [DATA_W-1:0] m_axi_wdata,
    output logic [STRB_W-1:0] m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [DATA_W-1:0] m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    localparam int CAW = CLW - 1;
    localparam int RAW = RLW - 1;

    typedef enum logic [2:0] {IDLE, WR, WR_B, RD_AR, RD_R, PUSH} state_t;

    state_t state, state_nxt;

    // ---------------- command ring ----------------
    logic              cmd_op_mem    [CMD_DEPTH];
    logic [ADDR_W-1:0] cmd_addr_mem  [CMD_DEPTH];
    logic [DATA_W-1:0] cmd_wdata_mem [CMD_DEPTH];
    logic [STRB_W-1:0] cmd_wstrb_mem [CMD_DEPTH];

    logic [CLW-1:0] cmd_wr_ptr, cmd_rd_ptr;
    logic           push_armed, push_acc, cmd_pop;

    assign cmd_level    = cmd_wr_ptr - cmd_rd_ptr;
    assign buffer_full  = (cmd_level == CLW'(CMD_DEPTH));
    assign buffer_empty = (cmd_level == '0);
    assign push_acc     = push_armed && cmd_push_req && !buffer_full;
    assign cmd_pop      = (state == PUSH);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_wr_ptr   <= '0;
            cmd_rd_ptr   <= '0;
            push_armed   <= 1'b1;
            cmd_push_ack <= 1'b0;
        end else begin
            cmd_push_ack <= push_acc;
            // A new push needs req to be seen low once after the previous accept.
            if (!cmd_push_req)
                push_armed <= 1'b1;
            else if (push_acc)
                push_armed <= 1'b0;
            if (push_acc)
                cmd_wr_ptr <= cmd_wr_ptr + CLW'(1);
            if (cmd_pop)
                cmd_rd_ptr <= cmd_rd_ptr + CLW'(1);
        end
    end

    always_ff @(posedge aclk) begin
        if (push_acc) begin
            cmd_op_mem[cmd_wr_ptr[CAW-1:0]]    <= cmd_push_struct_op;
            cmd_addr_mem[cmd_wr_ptr[CAW-1:0]]  <= cmd_push_struct_address;
            cmd_wdata_mem[cmd_wr_ptr[CAW-1:0]] <= cmd_push_struct_wdata;
            cmd_wstrb_mem[cmd_wr_ptr[CAW-1:0]] <= cmd_push_struct_wstrb;
        end
    end

    // ---------------- response ring status ----------------
    logic [RLW-1:0] resp_wr_ptr, resp_rd_ptr;
    logic           resp_full, pop_armed, pop_acc, resp_push;

    assign resp_level     = resp_wr_ptr - resp_rd_ptr;
    assign resp_full      = (resp_level == RLW'(RESP_DEPTH));
    assign resp_pop_ready = (resp_level != '0);
    assign pop_acc        = pop_armed && resp_pop_req && resp_pop_ready;
    assign resp_push      = (state == PUSH);

    // ---------------- engine ----------------
    logic              start;
    logic              ax_op;
    logic [ADDR_W-1:0] ax_addr;
    logic [DATA_W-1:0] ax_wdata;
    logic [STRB_W-1:0] ax_wstrb;
    logic              aw_done, w_done;
    logic [DATA_W-1:0] cap_rdata;
    logic [1:0]        cap_status;

    assign start = !buffer_empty && !resp_full;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start)
                       state_nxt = cmd_op_mem[cmd_rd_ptr[CAW-1:0]] ? RD_AR : WR;
            WR:    if ((aw_done || m_axi_awready) && (w_done || m_axi_wready))
                       state_nxt = WR_B;
            WR_B:  if (m_axi_bvalid)  state_nxt = PUSH;
            RD_AR: if (m_axi_arready) state_nxt = RD_R;
            RD_R:  if (m_axi_rvalid)  state_nxt = PUSH;
            PUSH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;
        case (state)
            WR: begin
                m_axi_awvalid = !aw_done;
                m_axi_wvalid  = !w_done;
            end
            WR_B:    m_axi_bready  = 1'b1;
            RD_AR:   m_axi_arvalid = 1'b1;
            RD_R:    m_axi_rready  = 1'b1;
            default: ;
        endcase
    end

    assign m_axi_awaddr = ax_addr;
    assign m_axi_araddr = ax_addr;
    assign m_axi_wdata  = ax_wdata;
    assign m_axi_wstrb  = ax_wstrb;
    assign m_axi_awprot = 3'b000;
    assign m_axi_arprot = 3'b000;

    // Payload is latched on dispatch so it stays stable while valid is up.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ax_op      <= 1'b0;
            ax_addr    <= '0;
            ax_wdata   <= '0;
            ax_wstrb   <= '0;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            cap_rdata  <= '0;
            cap_status <= '0;
        end else begin
            if (state == IDLE && start) begin
                ax_op    <= cmd_op_mem[cmd_rd_ptr[CAW-1:0]];
                ax_addr  <= cmd_addr_mem[cmd_rd_ptr[CAW-1:0]];
                ax_wdata <= cmd_wdata_mem[cmd_rd_ptr[CAW-1:0]];
                ax_wstrb <= cmd_wstrb_mem[cmd_rd_ptr[CAW-1:0]];
                aw_done  <= 1'b0;
                w_done   <= 1'b0;
            end
            if (m_axi_awvalid && m_axi_awready)
                aw_done <= 1'b1;
            if (m_axi_wvalid && m_axi_wready)
                w_done <= 1'b1;
            if (state == WR_B && m_axi_bvalid) begin
                cap_rdata  <= '0;
                cap_status <= m_axi_bresp;
            end
            if (state == RD_R && m_axi_rvalid) begin
                cap_rdata  <= m_axi_rdata;
                cap_status <= m_axi_rresp;
            end
        end
    end

    // ---------------- response ring ----------------
    logic              resp_op_mem     [RESP_DEPTH];
    logic [ADDR_W-1:0] resp_addr_mem   [RESP_DEPTH];
    logic [DATA_W-1:0] resp_rdata_mem  [RESP_DEPTH];
    logic [1:0]        resp_status_mem [RESP_DEPTH];

    always_ff @(posedge aclk) begin
        if (resp_push) begin
            resp_op_mem[resp_wr_ptr[RAW-1:0]]     <= ax_op;
            resp_addr_mem[resp_wr_ptr[RAW-1:0]]   <= ax_addr;
            resp_rdata_mem[resp_wr_ptr[RAW-1:0]]  <= cap_rdata;
            resp_status_mem[resp_wr_ptr[RAW-1:0]] <= cap_status;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            resp_wr_ptr             <= '0;
            resp_rd_ptr             <= '0;
            pop_armed               <= 1'b1;
            resp_pop_req_pulse      <= 1'b0;
            resp_pop_ack            <= 1'b0;
            resp_pop_struct_op      <= 1'b0;
            resp_pop_struct_address <= '0;
            resp_pop_struct_rdata   <= '0;
            resp_pop_struct_status  <= '0;
        end else begin
            resp_pop_req_pulse <= pop_acc;
            resp_pop_ack       <= resp_pop_req_pulse;
            if (!resp_pop_req)
                pop_armed <= 1'b1;
            else if (pop_acc)
                pop_armed <= 1'b0;
            if (pop_acc) begin
                resp_pop_struct_op      <= resp_op_mem[resp_rd_ptr[RAW-1:0]];
                resp_pop_struct_address <= resp_addr_mem[resp_rd_ptr[RAW-1:0]];
                resp_pop_struct_rdata   <= resp_rdata_mem[resp_rd_ptr[RAW-1:0]];
                resp_pop_struct_status  <= resp_status_mem[resp_rd_ptr[RAW-1:0]];
                resp_rd_ptr             <= resp_rd_ptr + RLW'(1);
            end
            if (resp_push)
                resp_wr_ptr <= resp_wr_ptr + RLW'(1);
        end
    end

`ifdef AXILITE_RB_ERR_CNT_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)
            err_count <= '0;
        else if (resp_push && cap_status[1] && err_count != '1)
            err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axilite_rb_master_p.sv
// Directed bench for axilite_rb_master_p against a small AXI4-Lite slave model with stall/error knobs.
// err_count checks are active when AXILITE_RB_ERR_CNT_EN is defined.
module tb_axilite_rb_master_p;

    logic        aclk;
    logic        aresetn;
    logic        cmd_push_req, cmd_push_ack, cmd_push_struct_op;
    logic [31:0] cmd_push_struct_address;
    logic [63:0] cmd_push_struct_wdata;
    logic [7:0]  cmd_push_struct_wstrb;
    logic        buffer_empty, buffer_full;
    logic [4:0]  cmd_level;
    logic        resp_pop_req, resp_pop_ack, resp_pop_req_pulse, resp_pop_ready;
    logic [4:0]  resp_level;
    logic        resp_pop_struct_op;
    logic [31:0] resp_pop_struct_address;
    logic [63:0] resp_pop_struct_rdata;
    logic [1:0]  resp_pop_struct_status;
`ifdef AXILITE_RB_ERR_CNT_EN
    logic [15:0] err_count;
`endif
    logic [31:0] m_axi_awaddr, m_axi_araddr;
    logic [2:0]  m_axi_awprot, m_axi_arprot;
    logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
    logic [63:0] m_axi_wdata, m_axi_rdata;
    logic [7:0]  m_axi_wstrb;
    logic [1:0]  m_axi_bresp, m_axi_rresp;
    logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
    logic        m_axi_rvalid, m_axi_rready;

    axilite_rb_master_p #(
        .ADDR_W(32), .DATA_W(64), .CMD_DEPTH(16), .RESP_DEPTH(16)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_push_req(cmd_push_req), .cmd_push_ack(cmd_push_ack),
        .cmd_push_struct_op(cmd_push_struct_op),
        .cmd_push_struct_address(cmd_push_struct_address),
        .cmd_push_struct_wdata(cmd_push_struct_wdata),
        .cmd_push_struct_wstrb(cmd_push_struct_wstrb),
        .buffer_empty(buffer_empty), .buffer_full(buffer_full), .cmd_level(cmd_level),
        .resp_pop_req(resp_pop_req), .resp_pop_ack(resp_pop_ack),
        .resp_pop_req_pulse(resp_pop_req_pulse), .resp_pop_ready(resp_pop_ready),
        .resp_level(resp_level),
        .resp_pop_struct_op(resp_pop_struct_op),
        .resp_pop_struct_address(resp_pop_struct_address),
        .resp_pop_struct_rdata(resp_pop_struct_rdata),
        .resp_pop_struct_status(resp_pop_struct_status),
`ifdef AXILITE_RB_ERR_CNT_EN
        .err_count(err_count),
`endif
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arprot(m_axi_arprot),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    // ---------------- slave model ----------------
    logic        stall, err;
    logic        aw_got, w_got;
    logic [31:0] aw_a;
    logic [63:0] w_d;
    logic [7:0]  w_s;
    logic [63:0] smem [128];
    int          txn_cnt = 0;

    assign m_axi_awready = !stall;
    assign m_axi_wready  = !stall;
    assign m_axi_arready = !stall;

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] s);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++)
            if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    always @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            aw_a         <= '0;
            w_d          <= '0;
            w_s          <= '0;
            m_axi_bvalid <= 1'b0;
            m_axi_bresp  <= 2'b00;
            m_axi_rvalid <= 1'b0;
            m_axi_rresp  <= 2'b00;
            m_axi_rdata  <= '0;
            for (int i = 0; i < 128; i++) smem[i] <= '0;
        end else begin
            if (m_axi_awvalid && m_axi_awready) begin
                aw_got <= 1'b1;
                aw_a   <= m_axi_awaddr;
            end
            if (m_axi_wvalid && m_axi_wready) begin
                w_got <= 1'b1;
                w_d   <= m_axi_wdata;
                w_s   <= m_axi_wstrb;
            end
            if (aw_got && w_got && !m_axi_bvalid) begin
                smem[aw_a[9:3]] <= merge(smem[aw_a[9:3]], w_d, w_s);
                m_axi_bvalid    <= 1'b1;
                m_axi_bresp     <= err ? 2'b10 : 2'b00;
                aw_got          <= 1'b0;
                w_got           <= 1'b0;
            end
            if (m_axi_bvalid && m_axi_bready) m_axi_bvalid <= 1'b0;
            if (m_axi_arvalid && m_axi_arready) begin
                m_axi_rvalid <= 1'b1;
                m_axi_rdata  <= smem[m_axi_araddr[9:3]];
                m_axi_rresp  <= err ? 2'b10 : 2'b00;
            end
            if (m_axi_rvalid && m_axi_rready) m_axi_rvalid <= 1'b0;
        end
    end

    always @(posedge aclk)
        if ((m_axi_awvalid && m_axi_awready) || (m_axi_arvalid && m_axi_arready))
            txn_cnt <= txn_cnt + 1;

    // ---------------- checking ----------------
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_cmd(input logic op, input logic [31:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input int hold);
        int n;
        cmd_push_struct_op      = op;
        cmd_push_struct_address = addr;
        cmd_push_struct_wdata   = data;
        cmd_push_struct_wstrb   = strb;
        cmd_push_req            = 1'b1;
        n = 0;
        while (!cmd_push_ack && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("push_ack", cmd_push_ack, 1'b1);
        repeat (hold) @(negedge aclk);
        cmd_push_req = 1'b0;
        @(negedge aclk);
    endtask

    task automatic pop_resp(output logic op, output logic [31:0] addr,
                            output logic [63:0] rdata, output logic [1:0] st);
        int n;
        n = 0;
        while (!resp_pop_ready && n < 200) begin
            @(negedge aclk);
            n++;
        end
        check("pop_ready_wait", resp_pop_ready, 1'b1);
        resp_pop_req = 1'b1;
        @(negedge aclk);
        check("pop_pulse", resp_pop_req_pulse, 1'b1);
        @(negedge aclk);
        check("pop_ack", resp_pop_ack, 1'b1);
        check("pop_pulse_1cyc", resp_pop_req_pulse, 1'b0);
        op    = resp_pop_struct_op;
        addr  = resp_pop_struct_address;
        rdata = resp_pop_struct_rdata;
        st    = resp_pop_struct_status;
        resp_pop_req = 1'b0;
        @(negedge aclk);
    endtask

    // ---------------- stimulus ----------------
    logic        p_op;
    logic [31:0] p_addr;
    logic [63:0] p_data;
    logic [1:0]  p_st;
    int          base, n;
    logic        ack_seen;

    initial begin
        aresetn = 1'b1;
        cmd_push_req = 1'b0;
        cmd_push_struct_op = 1'b0;
        cmd_push_struct_address = '0;
        cmd_push_struct_wdata = '0;
        cmd_push_struct_wstrb = '0;
        resp_pop_req = 1'b0;
        stall = 1'b0;
        err = 1'b0;
        #2 aresetn = 1'b0;
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);

        check("rst_empty", buffer_empty, 1'b1);
        check("rst_full", buffer_full, 1'b0);
        check("rst_cmd_level", cmd_level, 5'd0);
        check("rst_resp_level", resp_level, 5'd0);
        check("rst_pop_ready", resp_pop_ready, 1'b0);
        check("rst_awvalid", m_axi_awvalid, 1'b0);
        check("rst_arvalid", m_axi_arvalid, 1'b0);
`ifdef AXILITE_RB_ERR_CNT_EN
        check("rst_err_count", err_count, 16'd0);
`endif

        // Full-strobe write then read back
        push_cmd(1'b0, 32'h1000_0000, 64'hBADC_AFEE_BADC_AFEE, 8'hFF, 0);
        pop_resp(p_op, p_addr, p_data, p_st);
        check("wr_op", p_op, 1'b0);
        check("wr_addr", p_addr, 32'h1000_0000);
        check("wr_status", p_st, 2'b00);
        check("wr_rdata", p_data, 64'h0);
        check("slave_mem", smem[0], 64'hBADC_AFEE_BADC_AFEE);
        push_cmd(1'b1, 32'h1000_0000, 64'h0, 8'h00, 0);
        pop_resp(p_op, p_addr, p_data, p_st);
        check("rd_op", p_op, 1'b1);
        check("rd_addr", p_addr, 32'h1000_0000);
        check("rd_rdata", p_data, 64'hBADC_AFEE_BADC_AFEE);
        check("rd_status", p_st, 2'b00);

        // Partial strobe over a zero word
        push_cmd(1'b0, 32'h0000_0020, 64'hDEAD_BEEF_DEAD_BEEF, 8'h0F, 0);
        pop_resp(p_op, p_addr, p_data, p_st);
        check("strb_wr_status", p_st, 2'b00);
        push_cmd(1'b1, 32'h0000_0020, 64'h0, 8'h00, 0);
        pop_resp(p_op, p_addr, p_data, p_st);
        check("strb_rdata", p_data, 64'h0000_0000_DEAD_BEEF);

        // Stalled slave: fill the command ring, hold req high to test re-arm
        base  = txn_cnt;
        stall = 1'b1;
        push_cmd(1'b0, 32'h100, 64'd0, 8'hFF, 4);
        check("arm_hold_level", cmd_level, 5'd1);
        for (int i = 1; i < 16; i++)
            push_cmd(1'b0, 32'h100 + 32'(i * 8), 64'(i), 8'hFF, 0);
        check("full_level", cmd_level, 5'd16);
        check("full_flag", buffer_full, 1'b1);
        check("full_empty", buffer_empty, 1'b0);
        check("stall_awvalid", m_axi_awvalid, 1'b1);
        check("stall_wvalid", m_axi_wvalid, 1'b1);
        check("stall_awaddr", m_axi_awaddr, 32'h100);

        cmd_push_struct_op      = 1'b0;
        cmd_push_struct_address = 32'h180;
        cmd_push_struct_wdata   = 64'd16;
        cmd_push_struct_wstrb   = 8'hFF;
        cmd_push_req            = 1'b1;
        ack_seen = 1'b0;
        repeat (8) begin
            @(negedge aclk);
            ack_seen |= cmd_push_ack;
        end
        check("full_ack_withheld", ack_seen, 1'b0);
        stall = 1'b0;
        n = 0;
        while (!cmd_push_ack && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("pending_push_ack", cmd_push_ack, 1'b1);
        cmd_push_req = 1'b0;

        // Response ring fills with 16, 17th command must wait
        repeat (150) @(negedge aclk);
        check("rfull_resp_level", resp_level, 5'd16);
        check("rfull_cmd_level", cmd_level, 5'd1);
        check("rfull_txn", txn_cnt - base, 16);
        repeat (20) @(negedge aclk);
        check("rfull_txn_idle", txn_cnt - base, 16);
        check("rfull_awvalid", m_axi_awvalid, 1'b0);
        pop_resp(p_op, p_addr, p_data, p_st);
        check("rfull_pop_addr", p_addr, 32'h100);
        repeat (30) @(negedge aclk);
        check("one_more_txn", txn_cnt - base, 17);
        check("drained_cmd_level", cmd_level, 5'd0);
        check("drained_empty", buffer_empty, 1'b1);
        check("refill_resp_level", resp_level, 5'd16);
        for (int i = 1; i <= 16; i++) begin
            pop_resp(p_op, p_addr, p_data, p_st);
            check("drain_addr", p_addr, 64'(32'h100 + 32'(i * 8)));
        end
        check("drained_pop_ready", resp_pop_ready, 1'b0);

        // SLVERR on three writes
        err = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_cmd(1'b0, 32'h40 + 32'(i * 8), 64'h55, 8'hFF, 0);
            pop_resp(p_op, p_addr, p_data, p_st);
            check("slverr_status", p_st, 2'b10);
        end
        err = 1'b0;
`ifdef AXILITE_RB_ERR_CNT_EN
        check("err_count_3", err_count, 16'd3);
`endif

        // Reset while a response is buffered and a write is stalled
        push_cmd(1'b1, 32'h1000_0000, 64'h0, 8'h00, 0);
        n = 0;
        while (resp_level != 5'd1 && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("pre_rst_resp_level", resp_level, 5'd1);
        stall = 1'b1;
        push_cmd(1'b0, 32'h60, 64'h77, 8'hFF, 0);
        repeat (2) @(negedge aclk);
        check("pre_rst_awvalid", m_axi_awvalid, 1'b1);
        aresetn = 1'b0;
        #1;
        check("mid_rst_cmd_level", cmd_level, 5'd0);
        check("mid_rst_resp_level", resp_level, 5'd0);
        check("mid_rst_empty", buffer_empty, 1'b1);
        check("mid_rst_full", buffer_full, 1'b0);
        check("mid_rst_pop_ready", resp_pop_ready, 1'b0);
        check("mid_rst_awvalid", m_axi_awvalid, 1'b0);
        check("mid_rst_struct_addr", resp_pop_struct_address, 32'h0);
`ifdef AXILITE_RB_ERR_CNT_EN
        check("mid_rst_err_count", err_count, 16'd0);
`endif
        @(negedge aclk);
        aresetn = 1'b1;
        stall = 1'b0;
        repeat (5) @(negedge aclk);
        check("post_rst_awvalid", m_axi_awvalid, 1'b0);
        check("post_rst_cmd_level", cmd_level, 5'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axilite_rb_master_p.md
AXILITE_RB_MASTER_P -- requirements
Module: axilite_rb_master_p

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI/command address width.
REQ-002 SHALL have parameter DATA_W, default 64, data width (32 or 64); STRB_W=DATA_W/8.
REQ-003 SHALL have parameters CMD_DEPTH and RESP_DEPTH, default 16 each, powers of 2 >=2; LW=$clog2(depth)+1.
REQ-004 SHALL have port aclk, in, 1: sole clock, rising edge.
REQ-005 SHALL have port aresetn, in, 1: reset, asynchronous, active-low.
REQ-006 SHALL have ports cmd_push_req in 1, cmd_push_ack out 1, cmd_push_struct_op in 1 (0=write, 1=read), cmd_push_struct_address in ADDR_W, cmd_push_struct_wdata in DATA_W, cmd_push_struct_wstrb in STRB_W.
REQ-007 SHALL have outputs buffer_empty 1, buffer_full 1, cmd_level LW: command ring status.
REQ-008 SHALL have ports resp_pop_req in 1, resp_pop_ack out 1, resp_pop_req_pulse out 1, resp_pop_ready out 1, resp_level out LW.
REQ-009 SHALL have outputs resp_pop_struct_op 1, resp_pop_struct_address ADDR_W, resp_pop_struct_rdata DATA_W, resp_pop_struct_status 2.
REQ-010 SHALL have AXI4-Lite master ports m_axi_aw{addr,prot,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,prot,valid,ready}, m_axi_r{data,resp,valid,ready}; prot tied 3'b000.

Function
REQ-011 Push SHALL be armed by req low; accept when armed, req high, ring not full: write entry at tail, pulse cmd_push_ack 1 cycle next cycle, disarm until req returns low.
REQ-012 Push with ring full SHALL be held pending (no ack) and accepted the first cycle space exists.
REQ-013 buffer_full SHALL equal cmd_level==CMD_DEPTH; buffer_empty SHALL equal cmd_level==0; pointers wrap modulo depth via extra MSB.
REQ-014 Engine FSM SHALL have states IDLE, WR (AW and W valid concurrently, each dropped independently on its ready), WR_B, RD_AR, RD_R, PUSH.
REQ-015 IDLE->WR/RD_AR SHALL occur only when command ring non-empty AND response ring not full; one transaction outstanding.
REQ-016 bready/rready SHALL be high only in WR_B/RD_R; on handshake capture resp (and rdata for reads; rdata=0 for writes), go to PUSH.
REQ-017 PUSH SHALL write {op,address,rdata,status} to response ring, pop command ring, return to IDLE: one cycle.
REQ-018 resp_pop_ready SHALL equal resp_level!=0.
REQ-019 Pop SHALL use the same arm/accept rule as push: on accept, resp_pop_struct_* register head entry and resp_pop_req_pulse is high that cycle's output edge for 1 cycle; resp_pop_ack pulses the following cycle.
REQ-020 resp_pop_struct_* SHALL hold until next accepted pop.
REQ-021 Simultaneous push and engine pop on command ring, or PUSH and user pop on response ring, SHALL both take effect; level unchanged.
REQ-022 AXI valid signals SHALL not drop before their ready, and payload SHALL remain stable while valid.

Reset
REQ-023 aresetn low SHALL asynchronously clear pointers, levels, FSM to IDLE, all AXI valid/ready outputs, ack/pulse outputs, resp_pop_struct_* to 0, arm flags to armed.
REQ-024 Reset mid-transaction SHALL discard all buffered commands and responses; buffer_empty=1, buffer_full=0, resp_pop_ready=0 after reset.

Configuration
REQ-025 Macro AXILITE_RB_ERR_CNT_EN defined SHALL add output err_count 16: saturating count of responses with status[1]=1, cleared by reset.
REQ-026 Without AXILITE_RB_ERR_CNT_EN, err_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-027 Write 0x10000000, data 0xBADCAFEEBADCAFEE, strb 0xFF -> one AW/W, bready, pop yields op=0, addr 0x10000000, status 0, rdata 0.
REQ-028 Read back 0x10000000 after REQ-027 -> pop yields op=1, rdata 0xBADCAFEEBADCAFEE, status 0.
REQ-029 Slave stalled, push CMD_DEPTH+1 commands -> buffer_full=1 at 16, 17th ack withheld until first completion, then acked.
REQ-030 Response ring full (no pops) -> engine stays IDLE with commands pending; one pop -> exactly one further AXI transaction.
REQ-031 Strobe 0x0F write 0xDEADBEEFDEADBEEF over 0 then read -> rdata 0x00000000DEADBEEF.
REQ-032 With AXILITE_RB_ERR_CNT_EN, slave returns SLVERR on 3 writes -> status 2'b10 each, err_count=3; assert aresetn mid-write -> levels 0, err_count 0.
